// File: rtl/add8_recon_if.sv
// add8_recon_if: operand (diff/b) and result (sum/carry/zero) valid/ready channels for add8_recon.
interface add8_recon_if;
  logic       in_valid, in_ready, out_valid, out_ready, carry, zero;
  logic [7:0] diff, b, sum;
  modport slave (
    input  in_valid, diff, b, out_ready,
    output in_ready, out_valid, sum, carry, zero
  );
  modport master (
    output in_valid, diff, b, out_ready,
    input  in_ready, out_valid, sum, carry, zero
  );
endinterface

// File: rtl/add8_recon.sv
// add8_recon: two-stage pipelined 8-bit adder, sum = diff + b mod 256 with carry/zero flags.
// Low nibble is added in S1, high nibble is carry-selected on c4 into S2.
module add8_recon (
  input logic        clk,
  input logic        reset,
  add8_recon_if.slave io
);
  logic       s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [3:0] lo_q, dh_q, bh_q;
  logic       c4_q;
  logic [7:0] sum_q, sum_d;
  logic       carry_q, carry_d, zero_q, zero_d;
  logic [4:0] lo_d, hi0, hi1, hi;
  logic       adv2, accept;
  assign adv2        = s1_v_q & (~s2_v_q | io.out_ready);
  assign io.in_ready = ~s1_v_q | adv2;
  assign accept      = io.in_valid & io.in_ready;
  assign io.out_valid = s2_v_q;
  assign io.sum       = sum_q;
  assign io.carry     = carry_q;
  assign io.zero      = zero_q;
  always_comb begin
    s2_v_d  = adv2 ? 1'b1 : (io.out_ready ? 1'b0 : s2_v_q);
    s1_v_d  = accept ? 1'b1 : (adv2 ? 1'b0 : s1_v_q);
    lo_d    = {1'b0, io.diff[3:0]} + {1'b0, io.b[3:0]};
    hi0     = {1'b0, dh_q} + {1'b0, bh_q};
    hi1     = {1'b0, dh_q} + {1'b0, bh_q} + 5'd1;
    hi      = c4_q ? hi1 : hi0;
    sum_d   = {hi[3:0], lo_q};
    carry_d = hi[4];
    zero_d  = (sum_d == 8'h00);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      sum_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (adv2) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
      end
    end
  end
  // S1 data needs no reset: it is only observed through s1_v_q
  always_ff @(posedge clk) begin
    if (accept) begin
      {c4_q, lo_q} <= lo_d;
      dh_q         <= io.diff[7:4];
      bh_q         <= io.b[7:4];
    end
  end
endmodule

// File: tb/tb_add8_recon.sv
// tb_add8_recon: directed and round-trip self-checking bench for add8_recon.
module tb_add8_recon;
  logic clk, reset;
  int   checks = 0, errors = 0;
  add8_recon_if io ();
  add8_recon dut (.clk(clk), .reset(reset), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] s, input logic c, input logic z);
    chk({tag, "_valid"}, 16'(io.out_valid), 16'(v));
    chk({tag, "_sum"},   16'(io.sum),       16'(s));
    chk({tag, "_carry"}, 16'(io.carry),     16'(c));
    chk({tag, "_zero"},  16'(io.zero),      16'(z));
  endtask
  task automatic one(input string tag, input logic [7:0] d, input logic [7:0] bb,
                     input logic [7:0] s, input logic c, input logic z);
    io.in_valid = 1'b1; io.diff = d; io.b = bb; io.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 16'(io.in_ready), 16'd1);
    tick();
    io.in_valid = 1'b0;
    chk_out({tag, "_lat1"}, 1'b0, io.sum, io.carry, io.zero);
    tick();
    chk_out(tag, 1'b1, s, c, z);
    tick();
    chk({tag, "_drain"}, 16'(io.out_valid), 16'd0);
  endtask
  initial begin
    logic [7:0] ra, rb, ea, eb, st;
    logic [7:0] qa[$], qb[$];
    int sent, got;
    reset = 1'b0; io.in_valid = 1'b0; io.diff = 8'h00; io.b = 8'h00; io.out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    #1 chk("post_reset_in_ready", 16'(io.in_ready), 16'd1);
    one("basic",   8'h0F, 8'h05, 8'h14, 1'b0, 1'b0);
    one("ff_01",   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    one("80_80",   8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    one("00_00",   8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    one("nib_c4",  8'h39, 8'h48, 8'h81, 1'b0, 1'b0);
    one("c_nz",    8'hC8, 8'h7B, 8'h43, 1'b1, 1'b0);
    // streaming: result of operand c-1 visible after the edge of cycle c
    for (int c = 0; c < 12; c++) begin
      io.out_ready = 1'b1;
      io.in_valid  = (c < 10);
      io.diff      = 8'(c);
      io.b         = 8'(3 * c);
      #1 if (c < 10) chk("stream_in_ready", 16'(io.in_ready), 16'd1);
      tick();
      if (c >= 1 && c <= 10) begin
        chk("stream_valid", 16'(io.out_valid), 16'd1);
        chk("stream_sum", 16'(io.sum), 16'(8'(4 * (c - 1))));
      end
    end
    chk("stream_end_valid", 16'(io.out_valid), 16'd0);
    // backpressure: two accepts fill the pipe, third is refused
    io.out_ready = 1'b0; io.in_valid = 1'b1; io.diff = 8'h10; io.b = 8'h01;
    #1 chk("bp_acc1", 16'(io.in_ready), 16'd1);
    tick();
    io.diff = 8'h20; io.b = 8'h02;
    #1 chk("bp_acc2", 16'(io.in_ready), 16'd1);
    tick();
    io.diff = 8'h30; io.b = 8'h03;
    #1 chk("bp_full_in_ready", 16'(io.in_ready), 16'd0);
    chk_out("bp_hold0", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    io.diff = 8'h40; io.b = 8'h04;
    #1 chk("bp_full_in_ready2", 16'(io.in_ready), 16'd0);
    chk_out("bp_hold1", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    chk_out("bp_hold2", 1'b1, 8'h11, 1'b0, 1'b0);
    io.diff = 8'h30; io.b = 8'h03; io.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 16'(io.in_ready), 16'd1);
    tick();
    io.out_ready = 1'b0;
    #1 chk("bp_refill_in_ready", 16'(io.in_ready), 16'd0);
    chk_out("bp_next", 1'b1, 8'h22, 1'b0, 1'b0);
    // reset with both stages full and a pending operand
    io.diff = 8'h55; io.b = 8'h01;
    reset = 1'b0;
    tick();
    chk_out("midrst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("midrst_in_ready", 16'(io.in_ready), 16'd1);
    reset = 1'b1; io.in_valid = 1'b0; io.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_no_stale", 16'(io.out_valid), 16'd0);
    end
    // round trip against subtractor with random backpressure
    sent = 0; got = 0;
    ra = 8'($urandom); rb = 8'($urandom);
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      io.in_valid  = (sent < 1000);
      st           = ra - rb;
      io.diff      = st;
      io.b         = rb;
      io.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (io.out_valid && io.out_ready) begin
        if (qa.size() == 0) chk("rt_spurious", 16'(io.out_valid), 16'd0);
        else begin
          ea = qa.pop_front(); eb = qb.pop_front();
          chk("rt_sum", 16'(io.sum), 16'(ea));
          chk("rt_carry", 16'(io.carry), 16'(ea < eb));
          got++;
        end
      end
      if (io.in_valid && io.in_ready) begin
        qa.push_back(ra); qb.push_back(rb); sent++;
        ra = 8'($urandom); rb = 8'($urandom);
      end
      tick();
    end
    chk("rt_count", 16'(got), 16'd1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
